// File: rtl/array_mp_if.sv
// Request/response bundle for array_mp: NCH valid/ready request channels plus per-channel read return.
interface array_mp_if #(
    parameter int NCH = 2,
    parameter int AW  = 8,
    parameter int DW  = 8
) ();
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH-1:0]    in_we;
    logic [NCH*AW-1:0] in_addr;
    logic [NCH*DW-1:0] in_di;
    logic [NCH-1:0]    out_valid;
    logic [NCH*DW-1:0] out_do;

    modport master (
        output in_valid, in_we, in_addr, in_di,
        input  in_ready, out_valid, out_do
    );

    modport slave (
        input  in_valid, in_we, in_addr, in_di,
        output in_ready, out_valid, out_do
    );
endinterface

// File: rtl/array_mp.sv
// Shared word memory serving NCH valid/ready channels through a round-robin arbiter.
// Optional macro ARRAY_CLEAR_EN adds a clear port and a zeroing sweep (CLEAR/RUN FSM).
module array_mp #(
    parameter int NCH   = 2,
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic      clk,
    input  logic      reset,
`ifdef ARRAY_CLEAR_EN
    input  logic      clear,
`endif
    output logic      busy,
    array_mp_if.slave bus
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]     rrPtr_q, rrPtr_d;
    logic [PW-1:0]     grant;
    logic [PW:0]       probe;
    logic              found;
    logic              grantOk;
    logic              handshake;
    logic              selWe;
    logic [AW-1:0]     selAddr;
    logic [DW-1:0]     selDi;
    logic              inRange;
    logic [MW-1:0]     memIdx;
    logic [DW-1:0]     mem [DEPTH];
    logic [NCH-1:0]    outValid_q, outValid_d;
    logic [NCH*DW-1:0] outDo_q, outDo_d;
    logic              clrWe;
    logic [MW-1:0]     clrIdx;

    // Search channels starting at the round-robin pointer, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        grant = '0;
        probe = '0;
        for (int k = 0; k < NCH; k++) begin
            probe = {1'b0, rrPtr_q} + (PW+1)'(k);
            if (probe >= (PW+1)'(NCH)) begin
                probe = probe - (PW+1)'(NCH);
            end
            if (!found && bus.in_valid[probe[PW-1:0]]) begin
                found = 1'b1;
                grant = probe[PW-1:0];
            end
        end
    end

    assign grantOk   = found && !busy && !reset;
    assign handshake = grantOk;

    always_comb begin
        bus.in_ready = '0;
        if (grantOk) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    assign selWe   = bus.in_we[grant];
    assign selAddr = bus.in_addr[grant*AW +: AW];
    assign selDi   = bus.in_di[grant*DW +: DW];
    assign inRange = int'(selAddr) < DEPTH;
    assign memIdx  = selAddr[MW-1:0];

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (handshake) begin
            rrPtr_d = (grant == PW'(NCH - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Out-of-range reads still pulse out_valid but return zero.
    always_comb begin
        outValid_d = '0;
        outDo_d    = outDo_q;
        if (handshake && !selWe) begin
            outValid_d[grant]        = 1'b1;
            outDo_d[grant*DW +: DW]  = inRange ? mem[memIdx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr_q    <= '0;
            outValid_q <= '0;
            outDo_q    <= '0;
        end else begin
            rrPtr_q    <= rrPtr_d;
            outValid_q <= outValid_d;
            outDo_q    <= outDo_d;
        end
    end

    // Reset overrides a pulse already in flight.
    assign bus.out_valid = reset ? '0 : outValid_q;
    assign bus.out_do    = outDo_q;

    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem[clrIdx] <= '0;
        end else if (handshake && selWe && inRange) begin
            mem[memIdx] <= selDi;
        end
    end

`ifdef ARRAY_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state_q;
    logic [MW-1:0] clrAddr_q;
    logic          busy_q;

    // Sweep writes one address per cycle; clear is only honoured from RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clrAddr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clrAddr_q == MW'(DEPTH - 1)) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        clrAddr_q <= clrAddr_q + 1'b1;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state_q   <= CLEAR;
                        clrAddr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clrAddr_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign clrWe  = busy_q && !reset;
    assign clrIdx = clrAddr_q;
`else
    assign busy   = 1'b0;
    assign clrWe  = 1'b0;
    assign clrIdx = '0;
`endif
endmodule
